// File: rtl/network_mac_pkg.sv
// Shared types and helpers for the conv-layer MAC/requant block.
package network_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_PROD_W = 30;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 16;

  // Clamp a signed value into the range of a w-bit signed integer.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (value > hi)      sat_signed = hi;
    else if (value < lo) sat_signed = lo;
    else                 sat_signed = value;
  endfunction

endpackage

// File: rtl/network_requant_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of the biased
// window sum. Define NETWORK_MAC_RELU_EN to clamp negative results to zero.
import network_mac_pkg::*;

module network_requant_sat #(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = 14
) (
  input  logic signed [ACC_W:0]   sum,
  output logic signed [OUT_W-1:0] res
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic [ACC_W+1:0] RND = (SHIFT > 0) ?
    ({{(ACC_W+1){1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic signed [ACC_W+1:0] rnd;
  logic signed [ACC_W+1:0] shifted;
  logic signed [63:0]      wide;
  logic signed [63:0]      sat;
  logic signed [OUT_W-1:0] sat_out;
  logic [63-OUT_W:0]       sat_unused;

  assign rnd        = {sum[ACC_W], sum} + $signed(RND);
  assign shifted    = rnd >>> SHIFT;
  assign wide       = {{(64-ACC_W-2){shifted[ACC_W+1]}}, shifted};
  assign sat        = sat_signed(wide, OUT_W);
  assign sat_out    = sat[OUT_W-1:0];
  assign sat_unused = sat[63:OUT_W];

  // Final result, optionally passed through the fused ReLU.
  always_comb begin
    res = sat_out;
`ifdef NETWORK_MAC_RELU_EN
    if (sat_out[OUT_W-1]) res = '0;
`else
    res = sat_out;
`endif
  end

endmodule

// File: rtl/network_mac_requant.sv
// Kernel-window accumulator: sums products, adds scaled bias, requantizes to
// OUT_W and hands one result per window downstream over valid/ready.
// Optional fused ReLU is selected with NETWORK_MAC_RELU_EN.
import network_mac_pkg::*;

module network_mac_requant #(
  parameter int PROD_W     = DEF_PROD_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = 14,
  parameter int BIAS_SHIFT = 14,
  parameter int MAX_LEN    = 1024
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  input  logic signed [OUT_W-1:0]  bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     err
);

  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  state_t state, state_nxt;

  logic                    in_fire;
  logic                    out_fire;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W:0]   bias_ext;
  logic signed [ACC_W:0]   bias_sc;
  logic signed [ACC_W:0]   sum;
  logic signed [OUT_W-1:0] res;
  logic [CNT_W-1:0]        beat_cnt;

  // A held result blocks input unless it is being taken this very cycle.
  assign in_ready = (state != HOLD) || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Any beat outside ACC opens a new window, so it starts from zero.
  assign acc_base = (state == ACC) ? acc : '0;
  assign acc_nxt  = acc_base + {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign bias_ext = {{(ACC_W+1-OUT_W){bias_in[OUT_W-1]}}, bias_in};
  assign bias_sc  = bias_ext <<< BIAS_SHIFT;
  assign sum      = {acc_nxt[ACC_W-1], acc_nxt} + bias_sc;

  network_requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .sum (sum),
    .res (res)
  );

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; HOLD can chain straight into the next window.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire) state_nxt = in_last ? HOLD : ACC;
      ACC:  if (in_fire && in_last) state_nxt = HOLD;
      HOLD: begin
        if (out_fire) begin
          if (in_fire) state_nxt = in_last ? HOLD : ACC;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and window beat counter with sticky overrun flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (in_fire) begin
      acc <= acc_nxt;
      if (in_last) begin
        beat_cnt <= '0;
      end else if (beat_cnt == CNT_W'(MAX_LEN - 1)) begin
        err <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Output register: load on the last beat, drop valid once taken.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire && in_last) begin
      out_valid <= 1'b1;
      out_data  <= res;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_mac_requant.sv
// Directed self-checking bench for network_mac_requant.
module tb_network_mac_requant;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [29:0] in_prod;
  logic               in_last;
  logic signed [15:0] bias_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               err;

  int errs = 0;
  int checks = 0;

  network_mac_requant dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic beat(input logic signed [29:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = '0;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench finished)");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [63:0] exp_neg;
    ap_rst = 1'b1; in_valid = 0; in_prod = '0; in_last = 0;
    bias_in = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_err",       err, 0);
    ap_rst = 1'b0;
    chk("rst_in_ready",  in_ready, 1);

    // 1: three beats of 100.0 -> 300
    beat(30'sd1638400, 0);
    beat(30'sd1638400, 0);
    chk("t1_no_valid_early", out_valid, 0);
    beat(30'sd1638400, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 300);
    tick();
    chk("t1_taken", out_valid, 0);

    // 2: half-up rounding both signs
    beat(30'sd8192, 1);
    chk("t2_half_pos", out_data, 1);
    beat(-30'sd8192, 1);
    chk("t2_half_neg", out_data, 0);

    // 3: bias only, positive and negative saturation
    bias_in = 16'sd7;
    beat(30'sd0, 1);
    chk("t3_bias", out_data, 7);
    bias_in = 16'sd0;
    for (int i = 0; i < 4; i++) beat(30'sd536870911, i == 3);
    chk("t3_sat_pos", out_data, 32767);
    for (int i = 0; i < 4; i++) beat(-30'sd536870912, i == 3);
`ifdef NETWORK_MAC_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -32768;
`endif
    chk("t3_sat_neg", out_data, exp_neg);
    beat(-30'sd49152, 1);
`ifdef NETWORK_MAC_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -3;
`endif
    chk("t3_neg_small", out_data, exp_neg);
    tick();

    // 4: backpressure hold, then release with next window's beat
    out_ready = 1'b0;
    beat(30'sd147456, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data",  out_data, 9);
      chk("t4_in_ready",   in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_prod = 30'sd65536; in_last = 1'b1;
    #1;
    chk("t4_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_b2b_valid", out_valid, 1);
    chk("t4_b2b_data",  out_data, 4);
    tick();
    chk("t4_drained", out_valid, 0);

    // 5: overrun of MAX_LEN beats
    do_reset();
    for (int i = 0; i < 1023; i++) beat(30'sd0, 0);
    chk("t5_err_before", err, 0);
    beat(30'sd0, 0);
    beat(30'sd0, 0);
    chk("t5_err_set", err, 1);
    beat(30'sd0, 1);
    chk("t5_err_sticky", err, 1);
    chk("t5_result", out_data, 0);
    tick();
    do_reset();
    chk("t5_err_cleared", err, 0);

    // 6: reset mid-window discards partial sum
    beat(30'sd180224, 1);
    chk("t6_pre", out_data, 11);
    tick();
    beat(30'sd49152, 0);
    beat(30'sd49152, 0);
    do_reset();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data",  out_data, 0);
    chk("t6_rst_err",   err, 0);
    beat(30'sd81920, 1);
    chk("t6_valid", out_valid, 1);
    chk("t6_data",  out_data, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
